// File: rtl/layer_generator_pkg.sv
// Shared widths, encodings and small layer helpers for the layer generator.
package layer_generator_pkg;

   localparam int unsigned LAYER_WIDTH = 7;
   localparam int unsigned LFSR_WIDTH  = 16;
   localparam int unsigned COUNT_WIDTH = 3;
   localparam int unsigned TRY_WIDTH   = 4;

   localparam logic [LAYER_WIDTH-1:0] LAYER_RESET = 7'b0001000;
   // Fibonacci taps 16,14,13,11 as a mask over q[15:0]
   localparam logic [LFSR_WIDTH-1:0]  LFSR_TAPS   = 16'hB400;

   typedef logic [LAYER_WIDTH-1:0] layer_t;

   typedef struct packed {
      layer_t map;
      layer_t btype;
   } layer_s;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GEN    = 2'd1,
      ST_COMMIT = 2'd2
   } gen_state_e;

   function automatic logic [COUNT_WIDTH-1:0] popcount(input layer_t v);
      logic [COUNT_WIDTH-1:0] c;
      c = '0;
      for (int i = 0; i < int'(LAYER_WIDTH); i++) begin
         c = c + COUNT_WIDTH'(v[i]);
      end
      return c;
   endfunction

   function automatic layer_t lowest_set(input layer_t v);
      return v & layer_t'(~v + layer_t'(1));
   endfunction

   // Slots reachable by a one-slot jump from any block of v
   function automatic layer_t reach_mask(input layer_t v);
      return layer_t'((v << 1) | (v >> 1));
   endfunction

endpackage

// File: rtl/layer_generator_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, reloaded with the seed on reset.
module lfsr16
   import layer_generator_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [LFSR_WIDTH-1:0] seed,
   output logic [LFSR_WIDTH-1:0] q
);

   logic [LFSR_WIDTH-1:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= seed;
      end else begin
         lfsr_q <= {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)};
      end
   end

   assign q = lfsr_q;

endmodule

// File: rtl/layer_generator.sv
// Builds each new playable layer (map + fragile-block type) for the top of the shift_layer chain.
module layer_generator
   import layer_generator_pkg::*;
#(
   parameter logic [LFSR_WIDTH-1:0] SEED       = 16'hACE1,
   parameter int unsigned           MIN_BLOCKS = 2,
   parameter int unsigned           MAX_BLOCKS = 4,
   parameter int unsigned           MAX_TRIES  = 8
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   module_en,
   input  logic                   next_req,
   output logic [LAYER_WIDTH-1:0] layer_map,
   output logic [LAYER_WIDTH-1:0] block_type,
   output logic                   layer_valid
);

   localparam logic [COUNT_WIDTH-1:0] MIN_CNT  = COUNT_WIDTH'(MIN_BLOCKS);
   localparam logic [COUNT_WIDTH-1:0] MAX_CNT  = COUNT_WIDTH'(MAX_BLOCKS);
   localparam logic [TRY_WIDTH-1:0]   LAST_TRY = TRY_WIDTH'(MAX_TRIES - 1);

   gen_state_e            state_q;
   layer_t                layer_map_q;
   layer_t                block_type_q;
   layer_t                prev_q;
   logic                  layer_valid_q;
   logic                  pending_q;
   logic [TRY_WIDTH-1:0]  tries_q;
   logic [LFSR_WIDTH-1:0] lfsr;

   layer_t                cand_c;
   layer_t                type_raw_c;
   layer_t                reach_c;
   layer_t                hit_c;
   logic [COUNT_WIDTH-1:0] count_c;
   logic                  accept_c;
   layer_s                gen_d;
   logic                  unused_lfsr_bits;

   lfsr16 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .seed (SEED),
      .q    (lfsr)
   );

   assign unused_lfsr_bits = ^lfsr[LFSR_WIDTH-1:14];

   // Candidate evaluation: accept test, normal-block fix-up and fallback
   always_comb begin
      cand_c     = lfsr[LAYER_WIDTH-1:0];
      type_raw_c = lfsr[13:7] & cand_c;
      reach_c    = reach_mask(prev_q);
      hit_c      = cand_c & reach_c;
      count_c    = popcount(cand_c);
      accept_c   = (hit_c != '0) && (count_c >= MIN_CNT) && (count_c <= MAX_CNT);
      gen_d.map   = lowest_set(reach_c);
      gen_d.btype = '0;
      if (accept_c) begin
         gen_d.map   = cand_c;
         gen_d.btype = type_raw_c;
         if ((hit_c & ~type_raw_c) == '0) begin
            gen_d.btype = type_raw_c & ~lowest_set(hit_c);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         layer_map_q   <= LAYER_RESET;
         block_type_q  <= '0;
         prev_q        <= LAYER_RESET;
         layer_valid_q <= 1'b1;
         pending_q     <= 1'b0;
         tries_q       <= '0;
      end else if (!module_en) begin
         state_q       <= ST_IDLE;
         pending_q     <= 1'b0;
         layer_valid_q <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               layer_valid_q <= 1'b1;
               if (next_req) begin
                  prev_q        <= layer_map_q;
                  tries_q       <= '0;
                  layer_valid_q <= 1'b0;
                  state_q       <= ST_GEN;
               end
            end
            ST_GEN: begin
               if (next_req) begin
                  pending_q <= 1'b1;
               end
               if (accept_c || (tries_q == LAST_TRY)) begin
                  layer_map_q   <= gen_d.map;
                  block_type_q  <= gen_d.btype;
                  layer_valid_q <= 1'b1;
                  state_q       <= ST_COMMIT;
               end else begin
                  tries_q <= tries_q + TRY_WIDTH'(1);
               end
            end
            ST_COMMIT: begin
               // A request landing on the fresh layer itself is served straight away
               if (pending_q || next_req) begin
                  pending_q     <= 1'b0;
                  prev_q        <= layer_map_q;
                  tries_q       <= '0;
                  layer_valid_q <= 1'b0;
                  state_q       <= ST_GEN;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q       <= ST_IDLE;
               layer_valid_q <= 1'b1;
            end
         endcase
      end
   end

   assign layer_map   = layer_map_q;
   assign block_type  = block_type_q;
   assign layer_valid = layer_valid_q;

endmodule

// File: tb/tb_layer_generator.sv
// Directed bench for layer_generator: default instance plus a forced-fallback instance.
module tb_layer_generator;

   localparam int          MAX_TRIES = 8;
   localparam logic [15:0] SEED      = 16'hACE1;

   logic       clk = 1'b0;
   logic       rst;
   logic       en_a, en_b, next_req;
   logic [6:0] map_a, type_a, map_b, type_b;
   logic       valid_a, valid_b;

   int total = 0;
   int bad   = 0;

   logic [15:0] m_lfsr;
   logic [6:0]  exp_map [2];
   logic [6:0]  exp_type[2];

   always #5 clk = ~clk;

   layer_generator u_dut (
      .clk(clk), .rst(rst), .module_en(en_a), .next_req(next_req),
      .layer_map(map_a), .block_type(type_a), .layer_valid(valid_a)
   );

   layer_generator #(.MIN_BLOCKS(7), .MAX_BLOCKS(7)) u_fb (
      .clk(clk), .rst(rst), .module_en(en_b), .next_req(next_req),
      .layer_map(map_b), .block_type(type_b), .layer_valid(valid_b)
   );

   function automatic logic [15:0] lstep(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   // Reference LFSR runs every cycle, like the generator's
   always @(posedge clk) m_lfsr <= rst ? SEED : lstep(m_lfsr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] obs_map(input int w);
      return (w == 0) ? map_a : map_b;
   endfunction
   function automatic logic [6:0] obs_type(input int w);
      return (w == 0) ? type_a : type_b;
   endfunction
   function automatic logic obs_valid(input int w);
      return (w == 0) ? valid_a : valid_b;
   endfunction

   function automatic logic [6:0] reach_of(input logic [6:0] p);
      logic [6:0] r;
      r = 7'((p << 1) | (p >> 1));
      return r;
   endfunction

   function automatic logic [6:0] first_bit(input logic [6:0] v);
      for (int i = 0; i < 7; i++) if (v[i]) return 7'(1 << i);
      return 7'd0;
   endfunction

   // Expected layer starting from the LFSR value seen in the first GEN cycle
   task automatic predict(input logic [15:0] l0, input logic [6:0] prev, input int minb,
                          input int maxb, output logic [6:0] m, output logic [6:0] t,
                          output int used);
      logic [15:0] l;
      logic [6:0]  r, cand, ty;
      int          pc;
      l = l0;
      r = reach_of(prev);
      for (int i = 0; i < MAX_TRIES; i++) begin
         cand = l[6:0];
         ty   = l[13:7] & cand;
         pc   = $countones(cand);
         if ((cand & r) != 7'd0 && pc >= minb && pc <= maxb) begin
            if ((cand & r & ~ty) == 7'd0) ty = ty & ~first_bit(cand & r);
            m = cand; t = ty; used = i + 1;
            return;
         end
         l = lstep(l);
      end
      m = first_bit(r); t = 7'd0; used = MAX_TRIES;
   endtask

   task automatic props(input string tag, input logic [6:0] prev, input logic [6:0] m,
                        input logic [6:0] t);
      logic [6:0] r;
      r = reach_of(prev);
      chk({tag, "_reach"},  32'((m & r) != 7'd0), 32'd1);
      chk({tag, "_subset"}, 32'(t & ~m), 32'd0);
      chk({tag, "_normal"}, 32'((m & r & ~t) != 7'd0), 32'd1);
   endtask

   task automatic single_req(input string tag, input int w, input int minb, input int maxb,
                             output int used);
      logic [6:0] prev, m, t;
      int         n;
      en_a = (w == 0);
      en_b = (w == 1);
      next_req = 1'b1;
      tick();
      next_req = 1'b0;
      prev = exp_map[w];
      predict(m_lfsr, prev, minb, maxb, m, t, used);
      chk({tag, "_busy"}, 32'(obs_valid(w)), 32'd0);
      n = 1;
      while (!obs_valid(w) && n <= MAX_TRIES + 2) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(used + 1));
      chk({tag, "_map"},  32'(obs_map(w)),  32'(m));
      chk({tag, "_type"}, 32'(obs_type(w)), 32'(t));
      props(tag, prev, obs_map(w), obs_type(w));
      exp_map[w]  = m;
      exp_type[w] = t;
   endtask

   // Second request two cycles after the first, while the first is still in flight
   task automatic pair_req();
      logic        vv[1:30];
      logic [6:0]  mm[1:30], tt[1:30];
      logic [15:0] l0, l1;
      logic [6:0]  m1, t1, m2, t2;
      int          u1, u2;
      en_a = 1'b1;
      en_b = 1'b0;
      l0 = '0;
      for (int n = 1; n <= 30; n++) begin
         next_req = (n == 1) || (n == 3);
         tick();
         next_req = 1'b0;
         if (n == 1) l0 = m_lfsr;
         vv[n] = valid_a; mm[n] = map_a; tt[n] = type_a;
      end
      predict(l0, exp_map[0], 2, 4, m1, t1, u1);
      l1 = l0;
      for (int k = 0; k <= u1; k++) l1 = lstep(l1);
      predict(l1, m1, 2, 4, m2, t2, u2);
      chk("pair_busy",    32'(vv[1]), 32'd0);
      chk("pair_v1",      32'(vv[u1+1]), 32'd1);
      chk("pair_map1",    32'(mm[u1+1]), 32'(m1));
      chk("pair_type1",   32'(tt[u1+1]), 32'(t1));
      chk("pair_regen",   32'(vv[u1+2]), 32'd0);
      chk("pair_v2",      32'(vv[u1+u2+2]), 32'd1);
      chk("pair_map2",    32'(mm[u1+u2+2]), 32'(m2));
      chk("pair_type2",   32'(tt[u1+u2+2]), 32'(t2));
      chk("pair_settled", 32'(vv[30]), 32'd1);
      props("pair1", exp_map[0], mm[u1+1], tt[u1+1]);
      props("pair2", m1, mm[u1+u2+2], tt[u1+u2+2]);
      exp_map[0]  = m2;
      exp_type[0] = t2;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int u;
      rst = 1'b1; en_a = 1'b1; en_b = 1'b1; next_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int w = 0; w < 2; w++) begin
         exp_map[w]  = 7'b0001000;
         exp_type[w] = 7'd0;
      end

      chk("rst_map",    32'(map_a),   32'h08);
      chk("rst_type",   32'(type_a),  32'h00);
      chk("rst_valid",  32'(valid_a), 32'd1);
      chk("rst_map_fb", 32'(map_b),   32'h08);

      single_req("first", 0, 2, 4, u);
      chk("first_within", 32'(u <= MAX_TRIES), 32'd1);
      tick();

      // Forced fallback on the strict instance; the main one sits disabled meanwhile
      single_req("fb1", 1, 7, 7, u);
      if (u == MAX_TRIES) chk("fb1_fixed", 32'(map_b), 32'h04);
      single_req("fb2", 1, 7, 7, u);
      if (u == MAX_TRIES) chk("fb2_fixed", 32'(map_b), 32'h02);
      single_req("fb3", 1, 7, 7, u);
      if (u == MAX_TRIES) chk("fb3_fixed", 32'(map_b), 32'h01);
      single_req("fb4", 1, 7, 7, u);
      if (u == MAX_TRIES) begin
         chk("fb4_fixed", 32'(map_b), 32'h02);
         chk("fb4_type",  32'(type_b), 32'h00);
      end
      chk("dis_hold_map",   32'(map_a),   32'(exp_map[0]));
      chk("dis_hold_valid", 32'(valid_a), 32'd1);
      tick();

      pair_req();

      // Requests while disabled are ignored
      en_a = 1'b0;
      for (int k = 0; k < 3; k++) begin
         next_req = 1'b1; tick(); next_req = 1'b0; tick();
         chk("en0_map",   32'(map_a),   32'(exp_map[0]));
         chk("en0_valid", 32'(valid_a), 32'd1);
      end

      // Dropping the enable mid-generation abandons it
      en_a = 1'b1;
      next_req = 1'b1; tick(); next_req = 1'b0;
      en_a = 1'b0; tick();
      chk("abort_valid", 32'(valid_a), 32'd1);
      chk("abort_map",   32'(map_a),   32'(exp_map[0]));
      chk("abort_type",  32'(type_a),  32'(exp_type[0]));
      en_a = 1'b1; tick();

      // Reset during generation
      next_req = 1'b1; tick(); next_req = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst_map",   32'(map_a),   32'h08);
      chk("midrst_type",  32'(type_a),  32'h00);
      chk("midrst_valid", 32'(valid_a), 32'd1);
      chk("midrst_fb",    32'(map_b),   32'h08);
      for (int w = 0; w < 2; w++) begin
         exp_map[w]  = 7'b0001000;
         exp_type[w] = 7'd0;
      end
      single_req("after_rst", 0, 2, 4, u);

      for (int k = 0; k < 1500; k++) begin
         single_req("soak", 0, 2, 4, u);
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
